// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: BOOT/RUN/HALT FSM, IF/ID latch,
// branch redirect with flush, stall hold and a saturating fetch counter.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [1:0]  state,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

  state_t      st;
  if_id_t      if_id;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] cnt;

  assign pc_next     = pc + 32'd4;
  assign imem_addr   = pc;
  assign state       = st;
  assign if_id_pc    = if_id.pc;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_instr = if_id.instr;
  assign if_id_valid = if_id.valid;
  assign fetch_count = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= BOOT;
      pc    <= BOOT_PC;
      if_id <= '0;
      cnt   <= '0;
    end else begin
      unique case (st)
        BOOT: begin
          st          <= RUN;
          pc          <= BOOT_PC;
          if_id.valid <= 1'b0;
        end
        RUN: begin
          // Redirect beats stall and halt; only the valid bit is flushed.
          if (branch_taken) begin
            pc          <= {branch_target[31:2], 2'b00};
            if_id.valid <= 1'b0;
          end else if (stall) begin
            pc <= pc;
          end else if (halt) begin
            st          <= HALT;
            if_id.valid <= 1'b0;
          end else begin
            pc          <= pc_next;
            if_id.pc    <= pc;
            if_id.pc4   <= pc_next;
            if_id.instr <= imem_rdata;
            if_id.valid <= 1'b1;
            if (cnt != 32'hFFFF_FFFF)
              cnt <= cnt + 32'd1;
          end
        end
        HALT: begin
          if_id.valid <= 1'b0;
        end
        default: begin
          st          <= BOOT;
          if_id.valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Vector-table bench for pc_fetch_ctrl with a scoreboard queue
// and a free-running latency/pc4 sequence after a reset.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [1:0]  state;
  logic [31:0] fetch_count;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .state         (state),
    .fetch_count   (fetch_count)
  );

  localparam logic [31:0] K = 32'hA5A5_0000;

  assign imem_rdata = imem_addr ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        halt;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];
  vec_t sb[$];
  int   npass;
  int   ntot;

  function automatic vec_t mk(
    logic r, logic s, logic b, logic [31:0] t, logic h,
    logic [31:0] a, logic [31:0] p, logic [31:0] p4,
    logic [31:0] in, logic v, logic [1:0] st, logic [31:0] c);
    vec_t x;
    x.rst_n = r; x.stall = s; x.br = b; x.tgt = t; x.halt = h;
    x.addr = a; x.pc = p; x.pc4 = p4; x.instr = in;
    x.valid = v; x.st = st; x.cnt = c;
    return x;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt = 1'b0;

    //         rst s  b  tgt           h   addr          pc            pc4           instr         v  st cnt
    vt[0]  = mk(0, 0, 0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    vt[1]  = mk(1, 0, 0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0);
    vt[2]  = mk(1, 0, 0, 32'h0,        0,  32'h4,        32'h0,        32'h4,        K,            1, 1, 1);
    vt[3]  = mk(1, 0, 0, 32'h0,        0,  32'h8,        32'h4,        32'h8,        K^32'h4,      1, 1, 2);
    vt[4]  = mk(1, 1, 0, 32'h0,        0,  32'h8,        32'h4,        32'h8,        K^32'h4,      1, 1, 2);
    vt[5]  = mk(1, 1, 0, 32'h0,        0,  32'h8,        32'h4,        32'h8,        K^32'h4,      1, 1, 2);
    vt[6]  = mk(1, 1, 0, 32'h0,        1,  32'h8,        32'h4,        32'h8,        K^32'h4,      1, 1, 2);
    vt[7]  = mk(1, 0, 0, 32'h0,        0,  32'hC,        32'h8,        32'hC,        K^32'h8,      1, 1, 3);
    vt[8]  = mk(1, 1, 1, 32'h1003,     1,  32'h1000,     32'h8,        32'hC,        K^32'h8,      0, 1, 3);
    vt[9]  = mk(1, 0, 0, 32'h0,        0,  32'h1004,     32'h1000,     32'h1004,     K^32'h1000,   1, 1, 4);
    vt[10] = mk(1, 0, 1, 32'hFFFF_FFFC,0,  32'hFFFF_FFFC,32'h1000,     32'h1004,     K^32'h1000,   0, 1, 4);
    vt[11] = mk(1, 0, 0, 32'h0,        0,  32'h0,        32'hFFFF_FFFC,32'h0,        32'h5A5A_FFFC,1, 1, 5);
    vt[12] = mk(1, 0, 0, 32'h0,        0,  32'h4,        32'h0,        32'h4,        K,            1, 1, 6);
    vt[13] = mk(1, 0, 0, 32'h0,        1,  32'h4,        32'h0,        32'h4,        K,            0, 2, 6);
    vt[14] = mk(1, 1, 1, 32'h2000,     0,  32'h4,        32'h0,        32'h4,        K,            0, 2, 6);
    vt[15] = mk(1, 0, 0, 32'h0,        0,  32'h4,        32'h0,        32'h4,        K,            0, 2, 6);
    vt[16] = mk(0, 0, 1, 32'h3000,     1,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    vt[17] = mk(1, 1, 0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0);
    vt[18] = mk(1, 0, 0, 32'h0,        0,  32'h4,        32'h0,        32'h4,        K,            1, 1, 1);
    vt[19] = mk(0, 1, 0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      vec_t e;
      rst_n         = vt[i].rst_n;
      stall         = vt[i].stall;
      branch_taken  = vt[i].br;
      branch_target = vt[i].tgt;
      halt          = vt[i].halt;
      sb.push_back(vt[i]);
      step();
      e = sb.pop_front();
      chk("imem_addr",   i, imem_addr,          e.addr);
      chk("if_id_pc",    i, if_id_pc,           e.pc);
      chk("if_id_pc4",   i, if_id_pc4,          e.pc4);
      chk("if_id_instr", i, if_id_instr,        e.instr);
      chk("if_id_valid", i, {31'd0, if_id_valid}, {31'd0, e.valid});
      chk("state",       i, {30'd0, state},     {30'd0, e.st});
      chk("fetch_count", i, fetch_count,        e.cnt);
    end

    // Free run out of reset: one-cycle latency and pc4 = pc + 4.
    rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    step();
    chk("boot_state", 100, {30'd0, state}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = 32'(k) * 32'd4;
      step();
      chk("run_pc",    100 + k, if_id_pc,    a);
      chk("run_pc4",   100 + k, if_id_pc4,   a + 32'd4);
      chk("run_instr", 100 + k, if_id_instr, a ^ K);
      chk("run_addr",  100 + k, imem_addr,   a + 32'd4);
      chk("run_cnt",   100 + k, fetch_count, 32'(k + 1));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-004 Port stall, input, 1: hazard hold request from decode.
REQ-005 Port branch_taken, input, 1: redirect request from the stage that resolves branches.
REQ-006 Port branch_target, input, 32: redirect address.
REQ-007 Port halt, input, 1: stop fetching.
REQ-008 Port imem_addr, output, 32: instruction memory address, equal to current PC (combinational).
REQ-009 Port imem_rdata, input, 32: instruction word at imem_addr, valid in the same cycle.
REQ-010 Port if_id_pc, output, 32: PC of the latched instruction.
REQ-011 Port if_id_pc4, output, 32: if_id_pc + 4.
REQ-012 Port if_id_instr, output, 32: latched instruction word.
REQ-013 Port if_id_valid, output, 1: IF/ID register holds a real instruction.
REQ-014 Port state, output, 2: FSM state (BOOT=0, RUN=1, HALT=2).
REQ-015 Port fetch_count, output, 32: number of instructions delivered to IF/ID.

Function
REQ-016 FSM: BOOT -> RUN unconditionally after one cycle; RUN -> HALT when halt=1; HALT holds until reset; encoding 3 is unreachable and SHALL go to BOOT.
REQ-017 BOOT: PC holds RESET_PC; if_id_valid=0; no latch into IF/ID.
REQ-018 RUN priority per cycle: branch_taken > stall > halt > normal advance.
REQ-019 Normal advance: PC <= PC+4; IF/ID <= {PC, PC+4, imem_rdata}; if_id_valid <= 1; fetch_count increments.
REQ-020 Stall without branch: PC, if_id_pc, if_id_pc4, if_id_instr, if_id_valid and fetch_count hold.
REQ-021 Branch (RUN, regardless of stall or halt): PC <= {branch_target[31:2], 2'b00}; if_id_valid <= 0 (flush); other IF/ID fields hold; fetch_count holds.
REQ-022 Halt in RUN with no branch and no stall: PC holds; if_id_valid <= 0; enter HALT next cycle.
REQ-023 In HALT: stall, branch_taken and imem_rdata are ignored; PC and all IF/ID fields hold; if_id_valid=0.
REQ-024 PC arithmetic modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no error indication.
REQ-025 if_id_pc4 SHALL always equal if_id_pc + 4 modulo 2^32.
REQ-026 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 imem_addr[1:0] SHALL always be 2'b00.
REQ-028 Latency: an instruction at address A appears on if_id_instr one cycle after imem_addr=A in RUN without stall.

Reset
REQ-029 When rst_n=0 at a clock edge: PC <= RESET_PC; state <= BOOT; if_id_pc, if_id_pc4, if_id_instr <= 0; if_id_valid <= 0; fetch_count <= 0; this overrides every other input, including mid-stall, mid-branch and HALT.
REQ-030 Outputs before the first reset edge are unspecified; the bench SHALL NOT check them.

Verification
REQ-031 Reset then 4 free-running cycles, RESET_PC=0, imem_rdata=addr^32'hA5A5_0000 -> BOOT for one cycle; if_id_pc sequence 0,4,8; if_id_valid 0,1,1,1; fetch_count reaches 3.
REQ-032 Stall held 3 cycles while PC=8 -> imem_addr stays 8; if_id_pc stays 4; fetch_count is unchanged; on release if_id_pc=8 the next cycle.
REQ-033 branch_taken=1, stall=1, branch_target=32'h0000_1003 -> next cycle imem_addr=32'h0000_1000, if_id_valid=0; following cycle if_id_pc=32'h0000_1000, valid=1.
REQ-034 Branch to 32'hFFFF_FFFC then 2 normal cycles -> if_id_pc 32'hFFFF_FFFC then 32'h0000_0000; if_id_pc4 of the first is 32'h0000_0000.
REQ-035 halt=1 in RUN -> state=HALT next cycle; if_id_valid=0; PC frozen; a later branch_taken=1 has no effect; rst_n=0 for one cycle -> state=BOOT, PC=RESET_PC, fetch_count=0.
